// File: rtl/rename_map_table.sv
// Single-issue register rename stage: speculative and retirement RATs, one free-list pop per renamed rd.
// Optional free-list stall counter enabled by defining RENAME_STATS_EN.
module rename_map_table #(
  parameter int ARCH_ADDR_WIDTH = 5,
  parameter int PHYS_ADDR_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ARCH_ADDR_WIDTH-1:0] in_rs1,
  input  logic [ARCH_ADDR_WIDTH-1:0] in_rs2,
  input  logic [ARCH_ADDR_WIDTH-1:0] in_rd,
  input  logic                       in_rd_wr,
  output logic                       fl_rd_en,
  input  logic [PHYS_ADDR_WIDTH-1:0] fl_rd_data,
  input  logic                       fl_empty,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PHYS_ADDR_WIDTH-1:0] out_prs1,
  output logic [PHYS_ADDR_WIDTH-1:0] out_prs2,
  output logic [PHYS_ADDR_WIDTH-1:0] out_prd,
  output logic [PHYS_ADDR_WIDTH-1:0] out_old_prd,
  output logic                       out_rd_wr,
  input  logic                       commit_en,
  input  logic [ARCH_ADDR_WIDTH-1:0] commit_rd,
  input  logic [PHYS_ADDR_WIDTH-1:0] commit_prd,
  input  logic                       flush,
  output logic [31:0]                stall_cycles
);

  localparam int ARCH_REGS = 1 << ARCH_ADDR_WIDTH;

  logic [PHYS_ADDR_WIDTH-1:0] spec_rat [ARCH_REGS];
  logic [PHYS_ADDR_WIDTH-1:0] ret_rat  [ARCH_REGS];

  logic need_alloc;
  logic fire;
  logic commit_live;

  assign need_alloc  = in_rd_wr && (in_rd != '0);
  assign in_ready    = !flush && (!out_valid || out_ready) && (!need_alloc || !fl_empty);
  assign fire        = in_valid && in_ready;
  assign fl_rd_en    = fire && need_alloc;
  assign commit_live = commit_en && (commit_rd != '0);

  // Retirement RAT: x0 commits are dropped so entry 0 stays p0 forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) ret_rat[i] <= PHYS_ADDR_WIDTH'(i);
    end else if (commit_live) begin
      ret_rat[commit_rd] <= commit_prd;
    end
  end

  // Speculative RAT: flush recovery copies ret_rat with the same-cycle commit bypassed in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) spec_rat[i] <= PHYS_ADDR_WIDTH'(i);
    end else if (flush) begin
      for (int i = 0; i < ARCH_REGS; i++)
        spec_rat[i] <= (commit_live && (commit_rd == ARCH_ADDR_WIDTH'(i))) ? commit_prd : ret_rat[i];
    end else if (fl_rd_en) begin
      spec_rat[in_rd] <= fl_rd_data;
    end
  end

  // Sources read the RAT before this instruction's own rd update lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_prs1    <= '0;
      out_prs2    <= '0;
      out_prd     <= '0;
      out_old_prd <= '0;
      out_rd_wr   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid   <= 1'b1;
      out_prs1    <= spec_rat[in_rs1];
      out_prs2    <= spec_rat[in_rs2];
      out_prd     <= need_alloc ? fl_rd_data : '0;
      out_old_prd <= need_alloc ? spec_rat[in_rd] : '0;
      out_rd_wr   <= need_alloc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RENAME_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (in_valid && need_alloc && fl_empty && !flush) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_rename_map_table.sv
// Directed self-checking bench for rename_map_table with hand-computed expectations.
module tb_rename_map_table;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_rd_wr;
  logic        fl_rd_en;
  logic [5:0]  fl_rd_data;
  logic        fl_empty;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_prs1;
  logic [5:0]  out_prs2;
  logic [5:0]  out_prd;
  logic [5:0]  out_old_prd;
  logic        out_rd_wr;
  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [5:0]  commit_prd;
  logic        flush;
  logic [31:0] stall_cycles;

  int checks;
  int failures;
  logic [31:0] expStall;

  rename_map_table #(.ARCH_ADDR_WIDTH(5), .PHYS_ADDR_WIDTH(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr),
    .fl_rd_en(fl_rd_en), .fl_rd_data(fl_rd_data), .fl_empty(fl_empty),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_old_prd(out_old_prd), .out_rd_wr(out_rd_wr),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_prd(commit_prd),
    .flush(flush), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic wr, input logic [5:0] fl);
    in_valid   = v;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rd      = rd;
    in_rd_wr   = wr;
    fl_rd_data = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wr = 0;
    fl_rd_data = 0; fl_empty = 0; out_ready = 1;
    commit_en = 0; commit_rd = 0; commit_prd = 0; flush = 0;
    reset = 1;
    step();
    step();
    reset = 0;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    doReset();

    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_prd", out_prd, 0);
    checkOutput("rst_stall", stall_cycles, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    // add x5,x1,x2 with free-list head 32
    applyStimulus(1, 5'd1, 5'd2, 5'd5, 1, 6'd32);
    checkOutput("add_pop", fl_rd_en, 1);
    step();
    checkOutput("add_valid", out_valid, 1);
    checkOutput("add_prs1", out_prs1, 1);
    checkOutput("add_prs2", out_prs2, 2);
    checkOutput("add_prd", out_prd, 32);
    checkOutput("add_old_prd", out_old_prd, 5);
    checkOutput("add_rd_wr", out_rd_wr, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("add_pop_off", fl_rd_en, 0);
    step();
    checkOutput("drain_valid", out_valid, 0);

    // back-to-back dependent renames from a fresh map
    doReset();
    applyStimulus(1, 5'd5, 5'd1, 5'd5, 1, 6'd32);
    step();
    checkOutput("b2b0_prs1", out_prs1, 5);
    checkOutput("b2b0_prs2", out_prs2, 1);
    checkOutput("b2b0_prd", out_prd, 32);
    checkOutput("b2b0_old", out_old_prd, 5);
    applyStimulus(1, 5'd5, 5'd5, 5'd6, 1, 6'd33);
    checkOutput("b2b1_pop", fl_rd_en, 1);
    step();
    checkOutput("b2b1_prs1", out_prs1, 32);
    checkOutput("b2b1_prs2", out_prs2, 32);
    checkOutput("b2b1_prd", out_prd, 33);
    checkOutput("b2b1_old", out_old_prd, 6);

    // write to x0 then store: no allocation
    applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 6'd34);
    checkOutput("x0_pop", fl_rd_en, 0);
    step();
    checkOutput("x0_rd_wr", out_rd_wr, 0);
    checkOutput("x0_prd", out_prd, 0);
    checkOutput("x0_old", out_old_prd, 0);
    applyStimulus(1, 5'd0, 5'd5, 5'd7, 0, 6'd34);
    checkOutput("st_pop", fl_rd_en, 0);
    step();
    checkOutput("st_prs1_x0", out_prs1, 0);
    checkOutput("st_prs2", out_prs2, 32);
    checkOutput("st_rd_wr", out_rd_wr, 0);
    checkOutput("st_prd", out_prd, 0);

    // free list empty stalls an allocating instruction
    fl_empty = 1;
    applyStimulus(1, 5'd1, 5'd2, 5'd8, 1, 6'd34);
    for (int i = 0; i < 3; i++) begin
      checkOutput("empty_in_ready", in_ready, 0);
      checkOutput("empty_pop", fl_rd_en, 0);
      step();
    end
`ifdef RENAME_STATS_EN
    expStall = 32'd3;
`else
    expStall = 32'd0;
`endif
    checkOutput("empty_stall", stall_cycles, expStall);
    fl_empty = 0;
    #1;
    checkOutput("unempty_pop", fl_rd_en, 1);
    step();
    checkOutput("unempty_prd", out_prd, 34);
    checkOutput("unempty_old", out_old_prd, 8);
    checkOutput("unempty_stall", stall_cycles, expStall);

    // dispatch backpressure holds the output register
    out_ready = 0;
    applyStimulus(1, 5'd8, 5'd6, 5'd9, 1, 6'd35);
    for (int i = 0; i < 4; i++) begin
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_pop", fl_rd_en, 0);
      step();
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_prd", out_prd, 34);
      checkOutput("hold_old", out_old_prd, 8);
    end
    out_ready = 1;
    #1;
    checkOutput("release_pop", fl_rd_en, 1);
    step();
    checkOutput("release_prs1", out_prs1, 34);
    checkOutput("release_prs2", out_prs2, 33);
    checkOutput("release_prd", out_prd, 35);
    checkOutput("release_old", out_old_prd, 9);

    // commit, speculate further, then flush with a simultaneous commit
    doReset();
    applyStimulus(1, 5'd0, 5'd0, 5'd5, 1, 6'd32);
    step();
    checkOutput("fl_r0_prd", out_prd, 32);
    applyStimulus(0, 0, 0, 0, 0, 0);
    commit_en = 1; commit_rd = 5'd5; commit_prd = 6'd32;
    step();
    commit_en = 0;
    applyStimulus(1, 5'd0, 5'd0, 5'd5, 1, 6'd40);
    step();
    checkOutput("fl_r1_prd", out_prd, 40);
    checkOutput("fl_r1_old", out_old_prd, 32);
    flush = 1;
    commit_en = 1; commit_rd = 5'd7; commit_prd = 6'd41;
    applyStimulus(1, 5'd1, 5'd2, 5'd3, 1, 6'd50);
    checkOutput("flush_in_ready", in_ready, 0);
    checkOutput("flush_pop", fl_rd_en, 0);
    step();
    checkOutput("flush_valid", out_valid, 0);
    flush = 0;
    commit_en = 0;
    applyStimulus(1, 5'd5, 5'd7, 5'd0, 0, 6'd0);
    checkOutput("post_flush_ready", in_ready, 1);
    step();
    checkOutput("post_flush_valid", out_valid, 1);
    checkOutput("post_flush_prs1", out_prs1, 32);
    checkOutput("post_flush_prs2", out_prs2, 41);

    // reset while an output is in flight drops it
    applyStimulus(1, 5'd1, 5'd2, 5'd4, 1, 6'd42);
    step();
    checkOutput("pre_rst_valid", out_valid, 1);
    reset = 1;
    #1;
    checkOutput("async_rst_valid", out_valid, 0);
    checkOutput("async_rst_prd", out_prd, 0);
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
